bram_arbiter: RTL

Two-initiator Wishbone B4 (pipelined) arbiter that shares one single-port block RAM peripheral between independent requesters, e.g. the SPI host bridge and the video fetch engine. It sits between the two initiators and the RAM's Wishbone target port. It grants whole bus cycles with round-robin fairness and routes acknowledges and read data back to the owning initiator. It tracks outstanding transfers so that an acknowledge is never delivered to the wrong initiator across an ownership change.

---
 rtl/bram_arbiter_pkg.sv | 9 +
 rtl/bram_arbiter.sv | 66 ++++++
 2 files changed

// File: rtl/bram_arbiter_pkg.sv
// bram_arbiter_pkg: shared state encoding and initiator count for the BRAM arbiter
package bram_arbiter_pkg;
  localparam int NUM_INIT = 2;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;
endpackage

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin two-initiator Wishbone B4 pipelined arbiter for one BRAM target
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_PENDING = 1
) (
  input  logic                                 wb_clock_i,
  input  logic                                 wb_reset_i,
  input  logic [NUM_INIT-1:0][ADDR_WIDTH-1:0]  in_wb_addr_i,
  input  logic [NUM_INIT-1:0][DATA_WIDTH-1:0]  in_wb_data_i,
  output logic [NUM_INIT-1:0][DATA_WIDTH-1:0]  in_wb_data_o,
  input  logic [NUM_INIT-1:0]                  in_wb_we_i,
  input  logic [NUM_INIT-1:0]                  in_wb_cycle_i,
  input  logic [NUM_INIT-1:0]                  in_wb_strobe_i,
  output logic [NUM_INIT-1:0]                  in_wb_stall_o,
  output logic [NUM_INIT-1:0]                  in_wb_ack_o,
  output logic [ADDR_WIDTH-1:0]                t_wb_addr_o,
  output logic [DATA_WIDTH-1:0]                t_wb_data_o,
  input  logic [DATA_WIDTH-1:0]                t_wb_data_i,
  output logic                                 t_wb_we_o,
  output logic                                 t_wb_cycle_o,
  output logic                                 t_wb_strobe_o,
  input  logic                                 t_wb_stall_i,
  input  logic                                 t_wb_ack_i
);
  localparam int CW = $clog2(MAX_PENDING + 1);
  state_t        state, state_nx;
  logic [CW-1:0] count;
  logic          last, own, granted, own_cyc, full, accept, ack_ok;
  always_comb begin
    granted       = state != IDLE;
    own           = state == GRANT1;
    own_cyc       = in_wb_cycle_i[own];
    full          = count == CW'(MAX_PENDING);
    t_wb_addr_o   = in_wb_addr_i[own];
    t_wb_data_o   = in_wb_data_i[own];
    t_wb_we_o     = granted & in_wb_we_i[own];
    t_wb_cycle_o  = granted & own_cyc;
    t_wb_strobe_o = t_wb_cycle_o & in_wb_strobe_i[own] & !full;
    accept        = t_wb_strobe_o & !t_wb_stall_i;
    // acks with nothing outstanding are dropped; acks for an abandoned cycle only drain the count
    ack_ok        = t_wb_ack_i & (count != '0);
    in_wb_stall_o = {!(granted & own) | t_wb_stall_i | full, !(granted & !own) | t_wb_stall_i | full};
    in_wb_ack_o   = {granted & own, granted & !own} & {NUM_INIT{ack_ok & own_cyc}};
    in_wb_data_o  = {NUM_INIT{t_wb_data_i}};
    state_nx      = state;
    if (!granted)
      state_nx = &in_wb_cycle_i ? (last ? GRANT0 : GRANT1) :
                 in_wb_cycle_i[0] ? GRANT0 : in_wb_cycle_i[1] ? GRANT1 : IDLE;
    else if (!own_cyc && count == '0)
      state_nx = in_wb_cycle_i[!own] ? (own ? GRANT0 : GRANT1) : IDLE;
  end
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state <= IDLE;
      count <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      count <= count + CW'(accept) - CW'(ack_ok);
      if (granted && state_nx != state) last <= own;
    end
  end
endmodule
